// File: rtl/apple2_sdram_pkg.sv
// Shared definitions for the Apple II SDRAM slot arbiter: port indices,
// arbiter states, slot timing defaults and the per-slot grant picker.
package apple2_sdram_pkg;

    localparam int SLOT_LEN_DEF  = 8;
    localparam int RD_OFFSET_DEF = 6;

    typedef enum logic [1:0] {
        PORT_CPU = 2'd0,
        PORT_DMA = 2'd1,
        PORT_DL  = 2'd2
    } port_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACTIVE = 2'd2
    } arb_state_e;

    // One-hot grant {dl, dma, cpu}. CPU always wins; DMA and DL share the
    // remaining slots, with dl_prio choosing the winner when both ask.
    function automatic logic [2:0] pick_port(
        input logic cpu_req,
        input logic dma_req,
        input logic dl_req,
        input logic dl_prio
    );
        logic [2:0] grant;
        grant = 3'b000;
        if (cpu_req) begin
            grant = 3'b001;
        end else if (dma_req && dl_req) begin
            grant = dl_prio ? 3'b100 : 3'b010;
        end else if (dma_req) begin
            grant = 3'b010;
        end else if (dl_req) begin
            grant = 3'b100;
        end else begin
            grant = 3'b000;
        end
        return grant;
    endfunction

endpackage

// File: rtl/sdram_slot_timer.sv
// Slot timer: detects the rising edge of the 14 MHz reference and runs the
// phase counter 0..SLOT_LEN-1 inside each slot, holding at the last phase.
module sdram_slot_timer
    import apple2_sdram_pkg::*;
#(
    parameter int SLOT_LEN = SLOT_LEN_DEF,
    parameter int PHASE_W  = $clog2(SLOT_LEN)
) (
    input  logic               clk,
    input  logic               init_n,
    input  logic               clkref,
    output logic               slot_start,
    output logic [PHASE_W-1:0] phase
);

    logic               clkref_q;
    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] phase_d;

    // The previous sample resets high so a reference already high when reset
    // releases is not mistaken for a fresh edge.
    assign slot_start = clkref & ~clkref_q;
    assign phase      = phase_q;

    // Phase counter next state: restart on slot start, saturate at the end.
    always_comb begin
        phase_d = phase_q;
        if (slot_start) begin
            phase_d = {PHASE_W{1'b0}};
        end else if (phase_q < PHASE_W'(SLOT_LEN - 1)) begin
            phase_d = phase_q + PHASE_W'(1);
        end else begin
            phase_d = phase_q;
        end
    end

    // Reference sample and phase registers.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            clkref_q <= 1'b1;
            phase_q  <= {PHASE_W{1'b0}};
        end else begin
            clkref_q <= clkref;
            phase_q  <= phase_d;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Three-port SDRAM slot arbiter (CPU, disk DMA, ROM/image download).
// One access per clkref slot: the granted port's request is presented on the
// sd_* bus for the whole slot and completes with a single ack at RD_OFFSET.
// Build option: define SDRAM_ARB_DL_EN to arbitrate the download port; when
// undefined the download port is never granted and its outputs stay at zero.
module sdram_arbiter
    import apple2_sdram_pkg::*;
#(
    parameter int ADDR_W    = 25,
    parameter int RD_OFFSET = RD_OFFSET_DEF,
    parameter int SLOT_LEN  = SLOT_LEN_DEF
) (
    input  logic              clk,
    input  logic              init_n,
    input  logic              clkref,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_aux,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic [15:0]       cpu_dout,
    output logic              cpu_ack,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic              dma_aux,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [7:0]        dma_din,
    output logic [15:0]       dma_dout,
    output logic              dma_ack,

    input  logic              dl_req,
    input  logic              dl_we,
    input  logic              dl_aux,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [7:0]        dl_din,
    output logic [15:0]       dl_dout,
    output logic              dl_ack,

    output logic [ADDR_W-1:0] sd_addr,
    output logic              sd_we,
    output logic              sd_aux,
    output logic [7:0]        sd_din,
    input  logic [15:0]       sd_dout
);

    localparam int PHASE_W = $clog2(SLOT_LEN);

    logic               slot_start_s;
    logic [PHASE_W-1:0] phase_s;
    logic               dl_req_s;
    logic [2:0]         pick_s;
    logic               capture_s;

    arb_state_e         state_q, state_d;
    logic               grant_vld_q, grant_vld_d;
    port_e              grant_port_q, grant_port_d;
    logic               grant_we_q, grant_we_d;
    logic               dl_prio_q, dl_prio_d;

    logic [ADDR_W-1:0]  sd_addr_q, sd_addr_d;
    logic               sd_we_q, sd_we_d;
    logic               sd_aux_q, sd_aux_d;
    logic [7:0]         sd_din_q, sd_din_d;
    logic [15:0]        cpu_dout_q, cpu_dout_d;
    logic [15:0]        dma_dout_q, dma_dout_d;
    logic [15:0]        dl_dout_q, dl_dout_d;
    logic [2:0]         ack_q, ack_d;

    sdram_slot_timer #(
        .SLOT_LEN (SLOT_LEN),
        .PHASE_W  (PHASE_W)
    ) u_slot_timer (
        .clk        (clk),
        .init_n     (init_n),
        .clkref     (clkref),
        .slot_start (slot_start_s),
        .phase      (phase_s)
    );

`ifdef SDRAM_ARB_DL_EN
    assign dl_req_s = dl_req;
    assign dl_ack   = ack_q[2];
    assign dl_dout  = dl_dout_q;
`else
    logic unused_dl_s;
    assign dl_req_s    = 1'b0;
    assign dl_ack      = 1'b0;
    assign dl_dout     = 16'd0;
    assign unused_dl_s = ^{dl_req, dl_dout_q, ack_q[2]};
`endif

    assign pick_s = pick_port(cpu_req, dma_req, dl_req_s, dl_prio_q);

    // Data is latched on the edge that enters phase RD_OFFSET so the new dout
    // and the ack become visible together; a restarting slot cancels it.
    assign capture_s = (state_q == ST_ACTIVE) && grant_vld_q && !slot_start_s &&
                       (phase_s == PHASE_W'(RD_OFFSET - 1));

    assign cpu_ack  = ack_q[0];
    assign dma_ack  = ack_q[1];
    assign cpu_dout = cpu_dout_q;
    assign dma_dout = dma_dout_q;
    assign sd_addr  = sd_addr_q;
    assign sd_we    = sd_we_q;
    assign sd_aux   = sd_aux_q;
    assign sd_din   = sd_din_q;

    // Arbiter state register.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: every slot start enters ACTIVE, the end of the slot
    // drops back to WAIT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (slot_start_s) state_d = ST_ACTIVE;
                else              state_d = ST_IDLE;
            end
            ST_WAIT: begin
                if (slot_start_s) state_d = ST_ACTIVE;
                else              state_d = ST_WAIT;
            end
            ST_ACTIVE: begin
                if (slot_start_s)                               state_d = ST_ACTIVE;
                else if (phase_s == PHASE_W'(SLOT_LEN - 1))     state_d = ST_WAIT;
                else                                            state_d = ST_ACTIVE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Grant, SDRAM bus and completion next-state logic.
    always_comb begin
        grant_vld_d  = grant_vld_q;
        grant_port_d = grant_port_q;
        grant_we_d   = grant_we_q;
        dl_prio_d    = dl_prio_q;
        sd_addr_d    = sd_addr_q;
        sd_we_d      = sd_we_q;
        sd_aux_d     = sd_aux_q;
        sd_din_d     = sd_din_q;
        cpu_dout_d   = cpu_dout_q;
        dma_dout_d   = dma_dout_q;
        dl_dout_d    = dl_dout_q;
        ack_d        = 3'b000;

        if (slot_start_s) begin
            grant_vld_d = |pick_s;
            if (pick_s[0]) begin
                grant_port_d = PORT_CPU;
                grant_we_d   = cpu_we;
                sd_addr_d    = cpu_addr;
                sd_we_d      = cpu_we;
                sd_aux_d     = cpu_aux;
                sd_din_d     = cpu_din;
            end else if (pick_s[1]) begin
                grant_port_d = PORT_DMA;
                grant_we_d   = dma_we;
                dl_prio_d    = 1'b1;
                sd_addr_d    = dma_addr;
                sd_we_d      = dma_we;
                sd_aux_d     = dma_aux;
                sd_din_d     = dma_din;
            end else if (pick_s[2]) begin
                grant_port_d = PORT_DL;
                grant_we_d   = dl_we;
                dl_prio_d    = 1'b0;
                sd_addr_d    = dl_addr;
                sd_we_d      = dl_we;
                sd_aux_d     = dl_aux;
                sd_din_d     = dl_din;
            end else begin
                // Dummy read: keep the bus fields, just make sure no write.
                grant_we_d = 1'b0;
                sd_we_d    = 1'b0;
            end
        end else if (capture_s) begin
            grant_vld_d = 1'b0;
            case (grant_port_q)
                PORT_CPU: begin
                    ack_d[0] = 1'b1;
                    if (!grant_we_q) cpu_dout_d = sd_dout;
                    else             cpu_dout_d = cpu_dout_q;
                end
                PORT_DMA: begin
                    ack_d[1] = 1'b1;
                    if (!grant_we_q) dma_dout_d = sd_dout;
                    else             dma_dout_d = dma_dout_q;
                end
                PORT_DL: begin
                    ack_d[2] = 1'b1;
                    if (!grant_we_q) dl_dout_d = sd_dout;
                    else             dl_dout_d = dl_dout_q;
                end
                default: ack_d = 3'b000;
            endcase
        end else begin
            ack_d = 3'b000;
        end
    end

    // Grant bookkeeping, SDRAM bus and port result registers.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            grant_vld_q  <= 1'b0;
            grant_port_q <= PORT_CPU;
            grant_we_q   <= 1'b0;
            dl_prio_q    <= 1'b0;
            sd_addr_q    <= {ADDR_W{1'b0}};
            sd_we_q      <= 1'b0;
            sd_aux_q     <= 1'b0;
            sd_din_q     <= 8'd0;
            cpu_dout_q   <= 16'd0;
            dma_dout_q   <= 16'd0;
            dl_dout_q    <= 16'd0;
            ack_q        <= 3'b000;
        end else begin
            grant_vld_q  <= grant_vld_d;
            grant_port_q <= grant_port_d;
            grant_we_q   <= grant_we_d;
            dl_prio_q    <= dl_prio_d;
            sd_addr_q    <= sd_addr_d;
            sd_we_q      <= sd_we_d;
            sd_aux_q     <= sd_aux_d;
            sd_din_q     <= sd_din_d;
            cpu_dout_q   <= cpu_dout_d;
            dma_dout_q   <= dma_dout_d;
            dl_dout_q    <= dl_dout_d;
            ack_q        <= ack_d;
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed testbench for sdram_arbiter. Each slot is driven with a clkref
// rising edge; outputs are recorded at every falling edge of the slot so
// index k of the record arrays corresponds to phase k.
module tb_sdram_arbiter;

`ifdef SDRAM_ARB_DL_EN
    localparam bit DL_EN = 1'b1;
`else
    localparam bit DL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        init_n;
    logic        clkref;
    logic        cpu_req, cpu_we, cpu_aux;
    logic [24:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic [15:0] cpu_dout;
    logic        cpu_ack;
    logic        dma_req, dma_we, dma_aux;
    logic [24:0] dma_addr;
    logic [7:0]  dma_din;
    logic [15:0] dma_dout;
    logic        dma_ack;
    logic        dl_req, dl_we, dl_aux;
    logic [24:0] dl_addr;
    logic [7:0]  dl_din;
    logic [15:0] dl_dout;
    logic        dl_ack;
    logic [24:0] sd_addr;
    logic        sd_we, sd_aux;
    logic [7:0]  sd_din;
    logic [15:0] sd_dout;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_dma_dout = 16'h0000;
    logic [15:0] exp_dl_dout  = 16'h0000;

    logic        rec_cpu_ack [8];
    logic        rec_dma_ack [8];
    logic        rec_dl_ack  [8];
    logic [24:0] rec_sd_addr [8];
    logic        rec_sd_we   [8];
    logic        rec_sd_aux  [8];
    logic [7:0]  rec_sd_din  [8];
    logic [15:0] rec_cpu_dout[8];
    logic [15:0] rec_dma_dout[8];

    sdram_arbiter dut (
        .clk      (clk),
        .init_n   (init_n),
        .clkref   (clkref),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_aux  (cpu_aux),
        .cpu_addr (cpu_addr),
        .cpu_din  (cpu_din),
        .cpu_dout (cpu_dout),
        .cpu_ack  (cpu_ack),
        .dma_req  (dma_req),
        .dma_we   (dma_we),
        .dma_aux  (dma_aux),
        .dma_addr (dma_addr),
        .dma_din  (dma_din),
        .dma_dout (dma_dout),
        .dma_ack  (dma_ack),
        .dl_req   (dl_req),
        .dl_we    (dl_we),
        .dl_aux   (dl_aux),
        .dl_addr  (dl_addr),
        .dl_din   (dl_din),
        .dl_dout  (dl_dout),
        .dl_ack   (dl_ack),
        .sd_addr  (sd_addr),
        .sd_we    (sd_we),
        .sd_aux   (sd_aux),
        .sd_din   (sd_din),
        .sd_dout  (sd_dout)
    );

    always #5 clk = ~clk;

    // Raise clkref now (called just after a falling edge) and record len phases.
    task automatic slot_run(input int len);
        clkref = 1'b1;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            rec_cpu_ack[k]  = cpu_ack;
            rec_dma_ack[k]  = dma_ack;
            rec_dl_ack[k]   = dl_ack;
            rec_sd_addr[k]  = sd_addr;
            rec_sd_we[k]    = sd_we;
            rec_sd_aux[k]   = sd_aux;
            rec_sd_din[k]   = sd_din;
            rec_cpu_dout[k] = cpu_dout;
            rec_dma_dout[k] = dma_dout;
            if (k == 2) clkref = 1'b0;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (cpu_ack !== 1'b0 || dma_ack !== 1'b0 || dl_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_acks: got cpu=%b dma=%b dl=%b, expected all 0", cpu_ack, dma_ack, dl_ack);
        end
        checks++;
        if (sd_we !== 1'b0 || sd_aux !== 1'b0) begin
            errors++;
            $display("FAIL reset_sd_ctrl: got we=%b aux=%b, expected 0 0", sd_we, sd_aux);
        end
        checks++;
        if (sd_addr !== 25'h0000000 || sd_din !== 8'h00) begin
            errors++;
            $display("FAIL reset_sd_data: got addr=%h din=%h, expected 0 0", sd_addr, sd_din);
        end
        checks++;
        if (cpu_dout !== 16'h0000 || dma_dout !== 16'h0000 || dl_dout !== 16'h0000) begin
            errors++;
            $display("FAIL reset_dout: got cpu=%h dma=%h dl=%h, expected 0", cpu_dout, dma_dout, dl_dout);
        end
    endtask

    task automatic test_cpu_read();
        int nc, no;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_aux = 1'b0;
        cpu_addr = 25'h0000123; cpu_din = 8'h00; sd_dout = 16'hA55A;
        slot_run(8);
        cpu_req = 1'b0;
        nc = 0; no = 0;
        for (int k = 0; k < 8; k++) begin
            if (rec_cpu_ack[k] === 1'b1) nc++;
            if (rec_dma_ack[k] === 1'b1 || rec_dl_ack[k] === 1'b1) no++;
        end
        checks++;
        if (rec_sd_addr[0] !== 25'h0000123 || rec_sd_we[0] !== 1'b0) begin
            errors++;
            $display("FAIL cpu_read_bus: got addr=%h we=%b, expected 0000123 0", rec_sd_addr[0], rec_sd_we[0]);
        end
        checks++;
        if (nc != 1 || rec_cpu_ack[6] !== 1'b1) begin
            errors++;
            $display("FAIL cpu_read_ack: got %0d pulses, phase6=%b, expected 1 at phase 6", nc, rec_cpu_ack[6]);
        end
        checks++;
        if (rec_cpu_dout[6] !== 16'hA55A || rec_cpu_dout[5] !== 16'h0000) begin
            errors++;
            $display("FAIL cpu_read_dout: got ph5=%h ph6=%h, expected 0000 a55a", rec_cpu_dout[5], rec_cpu_dout[6]);
        end
        checks++;
        if (no != 0) begin
            errors++;
            $display("FAIL cpu_read_other_ack: got %0d, expected 0", no);
        end
        // Slot without any request: dummy read, bus fields held.
        sd_dout = 16'h0F0F;
        slot_run(8);
        nc = 0;
        for (int k = 0; k < 8; k++) begin
            if (rec_cpu_ack[k] === 1'b1 || rec_dma_ack[k] === 1'b1 || rec_dl_ack[k] === 1'b1) nc++;
        end
        checks++;
        if (rec_sd_we[0] !== 1'b0 || rec_sd_addr[0] !== 25'h0000123 || nc != 0 || rec_cpu_dout[7] !== 16'hA55A) begin
            errors++;
            $display("FAIL idle_dummy: got we=%b addr=%h acks=%0d dout=%h, expected 0 0000123 0 a55a",
                     rec_sd_we[0], rec_sd_addr[0], nc, rec_cpu_dout[7]);
        end
    endtask

    task automatic test_round_robin();
        int nd, nl, multi;
        logic exp_dl;
        logic [24:0] exp_addr;
        dma_req = 1'b1; dma_we = 1'b0; dma_aux = 1'b0; dma_addr = 25'h0000400; dma_din = 8'h00;
        dl_req  = 1'b1; dl_we  = 1'b0; dl_aux  = 1'b0; dl_addr  = 25'h0000500; dl_din  = 8'h00;
        multi = 0;
        for (int i = 0; i < 4; i++) begin
            sd_dout = 16'h1100 + 16'(i);
            slot_run(8);
            exp_dl   = DL_EN && (i % 2 == 1);
            exp_addr = exp_dl ? 25'h0000500 : 25'h0000400;
            nd = 0; nl = 0;
            for (int k = 0; k < 8; k++) begin
                if (rec_dma_ack[k] === 1'b1) nd++;
                if (rec_dl_ack[k] === 1'b1) nl++;
                if (int'(rec_cpu_ack[k] === 1'b1) + int'(rec_dma_ack[k] === 1'b1) + int'(rec_dl_ack[k] === 1'b1) > 1) multi++;
            end
            checks++;
            if (rec_sd_addr[0] !== exp_addr) begin
                errors++;
                $display("FAIL rr_addr slot %0d: got %h, expected %h", i, rec_sd_addr[0], exp_addr);
            end
            checks++;
            if (exp_dl ? (nd != 0 || nl != 1 || rec_dl_ack[6] !== 1'b1)
                       : (nd != 1 || nl != 0 || rec_dma_ack[6] !== 1'b1)) begin
                errors++;
                $display("FAIL rr_ack slot %0d: got dma=%0d dl=%0d, expected dl_granted=%b", i, nd, nl, exp_dl);
            end
            if (exp_dl) exp_dl_dout = sd_dout;
            else        exp_dma_dout = sd_dout;
        end
        dma_req = 1'b0; dl_req = 1'b0;
        checks++;
        if (dma_dout !== exp_dma_dout || dl_dout !== exp_dl_dout) begin
            errors++;
            $display("FAIL rr_dout: got dma=%h dl=%h, expected %h %h", dma_dout, dl_dout, exp_dma_dout, exp_dl_dout);
        end
        checks++;
        if (multi != 0) begin
            errors++;
            $display("FAIL rr_one_ack: got %0d cycles with several acks, expected 0", multi);
        end
    endtask

    task automatic test_cpu_priority();
        int nc, nd;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h0000200;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 25'h0000300;
        sd_dout = 16'h2222;
        for (int i = 0; i < 3; i++) begin
            slot_run(8);
            nc = 0; nd = 0;
            for (int k = 0; k < 8; k++) begin
                if (rec_cpu_ack[k] === 1'b1) nc++;
                if (rec_dma_ack[k] === 1'b1) nd++;
            end
            checks++;
            if (rec_sd_addr[0] !== 25'h0000200 || nc != 1 || nd != 0) begin
                errors++;
                $display("FAIL prio_cpu slot %0d: got addr=%h cpu=%0d dma=%0d, expected 0000200 1 0",
                         i, rec_sd_addr[0], nc, nd);
            end
        end
        cpu_req = 1'b0;
        sd_dout = 16'h3333;
        slot_run(8);
        dma_req = 1'b0;
        nd = 0;
        for (int k = 0; k < 8; k++) if (rec_dma_ack[k] === 1'b1) nd++;
        checks++;
        if (rec_sd_addr[0] !== 25'h0000300 || nd != 1 || rec_dma_ack[6] !== 1'b1 || rec_dma_dout[6] !== 16'h3333) begin
            errors++;
            $display("FAIL prio_dma_after: got addr=%h acks=%0d dout=%h, expected 0000300 1 3333",
                     rec_sd_addr[0], nd, rec_dma_dout[6]);
        end
        exp_dma_dout = 16'h3333;
    endtask

    task automatic test_dma_write();
        int good, nd;
        dma_req = 1'b1; dma_we = 1'b1; dma_aux = 1'b1; dma_addr = 25'h0010000; dma_din = 8'h5C;
        sd_dout = 16'hBEEF;
        slot_run(8);
        dma_req = 1'b0; dma_we = 1'b0; dma_aux = 1'b0;
        good = 0; nd = 0;
        for (int k = 0; k < 8; k++) begin
            if (rec_sd_we[k] === 1'b1 && rec_sd_din[k] === 8'h5C && rec_sd_aux[k] === 1'b1 &&
                rec_sd_addr[k] === 25'h0010000) good++;
            if (rec_dma_ack[k] === 1'b1) nd++;
        end
        checks++;
        if (good != 8) begin
            errors++;
            $display("FAIL write_hold: got %0d phases with write fields, expected 8", good);
        end
        checks++;
        if (nd != 1 || rec_dma_ack[6] !== 1'b1) begin
            errors++;
            $display("FAIL write_ack: got %0d pulses, phase6=%b, expected 1 at phase 6", nd, rec_dma_ack[6]);
        end
        checks++;
        if (rec_dma_dout[7] !== exp_dma_dout) begin
            errors++;
            $display("FAIL write_dout: got %h, expected %h", rec_dma_dout[7], exp_dma_dout);
        end
        slot_run(8);
        checks++;
        if (rec_sd_we[0] !== 1'b0 || rec_sd_din[0] !== 8'h5C || rec_sd_aux[0] !== 1'b1) begin
            errors++;
            $display("FAIL write_then_idle: got we=%b din=%h aux=%b, expected 0 5c 1",
                     rec_sd_we[0], rec_sd_din[0], rec_sd_aux[0]);
        end
    endtask

    task automatic test_reset_mid_slot();
        int bad, nc;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_aux = 1'b0; cpu_addr = 25'h0000777;
        sd_dout = 16'h7777;
        slot_run(4);
        checks++;
        if (rec_sd_addr[0] !== 25'h0000777) begin
            errors++;
            $display("FAIL rst_pre_grant: got %h, expected 0000777", rec_sd_addr[0]);
        end
        init_n = 1'b0;
        clkref = 1'b1;
        @(negedge clk);
        checks++;
        if (cpu_ack !== 1'b0 || sd_addr !== 25'h0000000 || sd_we !== 1'b0 || sd_din !== 8'h00 ||
            sd_aux !== 1'b0 || cpu_dout !== 16'h0000 || dma_dout !== 16'h0000) begin
            errors++;
            $display("FAIL rst_mid_outputs: got ack=%b addr=%h we=%b din=%h aux=%b cpu_dout=%h dma_dout=%h, expected zeros",
                     cpu_ack, sd_addr, sd_we, sd_din, sd_aux, cpu_dout, dma_dout);
        end
        repeat (2) @(negedge clk);
        init_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (cpu_ack !== 1'b0 || sd_addr !== 25'h0000000 || sd_we !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rst_no_early_grant: got %0d bad cycles, expected 0", bad);
        end
        clkref = 1'b0;
        @(negedge clk);
        slot_run(8);
        cpu_req = 1'b0;
        nc = 0;
        for (int k = 0; k < 8; k++) if (rec_cpu_ack[k] === 1'b1) nc++;
        checks++;
        if (rec_sd_addr[0] !== 25'h0000777 || nc != 1 || rec_cpu_dout[6] !== 16'h7777) begin
            errors++;
            $display("FAIL rst_regrant: got addr=%h acks=%0d dout=%h, expected 0000777 1 7777",
                     rec_sd_addr[0], nc, rec_cpu_dout[6]);
        end
    endtask

    task automatic test_slot_restart();
        int n1, n2;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_aux = 1'b0; cpu_addr = 25'h0000ABC;
        sd_dout = 16'h1234;
        slot_run(5);
        n1 = 0;
        for (int k = 0; k < 5; k++) if (rec_cpu_ack[k] === 1'b1) n1++;
        checks++;
        if (rec_sd_addr[0] !== 25'h0000ABC || n1 != 0) begin
            errors++;
            $display("FAIL restart_first: got addr=%h acks=%0d, expected 0000abc 0", rec_sd_addr[0], n1);
        end
        slot_run(8);
        cpu_req = 1'b0;
        n2 = 0;
        for (int k = 0; k < 8; k++) if (rec_cpu_ack[k] === 1'b1) n2++;
        checks++;
        if (rec_sd_addr[0] !== 25'h0000ABC || rec_cpu_ack[6] !== 1'b1 || rec_cpu_dout[6] !== 16'h1234) begin
            errors++;
            $display("FAIL restart_regrant: got addr=%h ack6=%b dout=%h, expected 0000abc 1 1234",
                     rec_sd_addr[0], rec_cpu_ack[6], rec_cpu_dout[6]);
        end
        checks++;
        if (n1 + n2 != 1) begin
            errors++;
            $display("FAIL restart_ack_count: got %0d, expected 1", n1 + n2);
        end
    endtask

    initial begin
        init_n = 1'b0; clkref = 1'b0; sd_dout = 16'h0000;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_aux = 1'b0; cpu_addr = 25'h0000000; cpu_din = 8'h00;
        dma_req = 1'b0; dma_we = 1'b0; dma_aux = 1'b0; dma_addr = 25'h0000000; dma_din = 8'h00;
        dl_req  = 1'b0; dl_we  = 1'b0; dl_aux  = 1'b0; dl_addr  = 25'h0000000; dl_din  = 8'h00;
        repeat (3) @(negedge clk);
        test_reset();
        init_n = 1'b1;
        repeat (3) @(negedge clk);
        test_cpu_read();
        test_round_robin();
        test_cpu_priority();
        test_dma_write();
        test_reset_mid_slot();
        test_slot_restart();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 25, byte address width; RD_OFFSET, 6, clk cycles from slot start to read-data capture; SLOT_LEN, 8, clk cycles per access slot.
REQ-002 clk  in  1  SDRAM clock, 8x the 14 MHz reference; the only clock.
REQ-003 init_n  in  1  asynchronous, active-low reset.
REQ-004 clkref  in  1  14 MHz reference level, synchronous to clk; a rising edge marks a slot start.
REQ-005 cpu_req, cpu_we, cpu_aux  in  1 each  CPU port: level request, write, upper-byte select.
REQ-006 cpu_addr  in  ADDR_W; cpu_din  in  8; cpu_dout  out  16; cpu_ack  out  1  CPU port address, data and completion pulse.
REQ-007 dma_req, dma_we, dma_aux, dma_addr, dma_din, dma_dout, dma_ack  same widths  disk DMA port.
REQ-008 dl_req, dl_we, dl_aux, dl_addr, dl_din, dl_dout, dl_ack  same widths  ROM/image download port.
REQ-009 sd_addr  out  ADDR_W; sd_we, sd_aux  out  1; sd_din  out  8; sd_dout  in  16  SDRAM controller side.

Function
REQ-010 A slot start SHALL be the first clk after clkref is sampled 0 then 1; phase counter resets to 0 there and increments to SLOT_LEN-1, then holds until the next slot start.
REQ-011 At phase 0 the arbiter SHALL grant at most one port: CPU if cpu_req=1; otherwise round-robin between DMA and DL, last-granted of the two losing a tie.
REQ-012 Granted port's addr/we/aux/din SHALL be registered onto sd_* at phase 0 and held constant until the next slot start.
REQ-013 With no grant, sd_we SHALL be 0 and sd_addr/sd_din/sd_aux SHALL hold previous values (dummy read).
REQ-014 Read grant: at phase RD_OFFSET, sd_dout SHALL be registered into the granted port's dout and its ack pulsed high exactly one clk in the same cycle the dout update becomes visible.
REQ-015 Write grant: ack SHALL pulse one clk at phase RD_OFFSET; dout unchanged.
REQ-016 Requesters SHALL hold req and request fields stable until ack; req must drop or present a new request in the clk after ack; req held high after ack is a new request.
REQ-017 req deasserted before phase 0 SHALL not be granted; deassertion after grant SHALL not cancel the access.
REQ-018 States: IDLE (no slot seen since reset), WAIT (between slots), ACTIVE (phase 0..SLOT_LEN-1 of granted slot); IDLE->ACTIVE / WAIT->ACTIVE on slot start; ACTIVE->WAIT after phase SLOT_LEN-1.
REQ-019 A slot start arriving before phase SLOT_LEN-1 SHALL restart phase 0; a pending ack of the aborted slot is not issued and that request is re-arbitrated.
REQ-020 At most one ack across all ports SHALL be high in any clk.

Reset
REQ-021 While init_n=0: state IDLE, phase 0, all acks 0, sd_we 0, sd_addr 0, sd_din 0, sd_aux 0, all dout 0, round-robin pointer to DMA.
REQ-022 Reset assertion mid-slot SHALL abort the access with no ack; first grant after release occurs only at a fresh slot start.

Configuration
REQ-023 Macro SDRAM_ARB_DL_EN: defined -> DL port arbitrated as above; undefined -> DL port never granted, dl_ack constant 0, dl_dout constant 0, DMA gets every non-CPU slot.

Structure
REQ-024 Shared package apple2_sdram_pkg SHALL hold the port-index enum (CPU, DMA, DL), arbiter state enum, and SLOT_LEN/RD_OFFSET defaults.
REQ-025 Sub-module sdram_slot_timer SHALL contain clkref edge detection and the phase counter, emitting slot_start and phase.

Verification
REQ-026 cpu_req=1 read at 0x000123, sd_dout=0xA55A -> sd_addr=0x000123 at phase 0, cpu_dout=0xA55A and cpu_ack=1 for one clk at phase 6.
REQ-027 cpu_req and dma_req both held for 3 slots -> three CPU grants, no dma_ack; CPU drops -> DMA granted next slot.
REQ-028 dma_req and dl_req held continuously, CPU idle -> grants alternate DMA, DL, DMA, DL; with SDRAM_ARB_DL_EN undefined -> DMA every slot, dl_ack never 1.
REQ-029 dma write addr 0x010000 din 0x5C aux 1 -> sd_we=1, sd_din=0x5C, sd_aux=1 held 8 clks, dma_ack at phase 6, dma_dout unchanged.
REQ-030 init_n pulsed low at phase 3 of a CPU read -> no cpu_ack, all outputs at reset values; after release, no grant before next clkref rising edge.
REQ-031 clkref rising edge at phase 4 -> phase restarts at 0, aborted request re-granted, exactly one ack for it.
